if_stage: RTL
=============

# if_stage

Instruction-fetch stage of the 16-bit MIPS pipeline, directly upstream of instruction decode. Owns the program counter, issues single-outstanding requests to instruction memory, and drives the IF/ID pipeline register (instruction, PC+1, valid) that decode consumes. Supports decode stalls through a one-entry holding buffer and branch/jump redirects that flush in-flight fetches.

## Interface
- PC_W, 16, PC width; word-addressed, one 16-bit instruction per address
- INST_W, 16, instruction width
- RESET_PC, 0, PC value loaded on reset
- clk  in  1  pipeline clock, rising edge
- rst  in  1  reset; asynchronous and active-high, applies to all state
- imem_req  out  1  one-cycle request pulse to instruction memory
- imem_addr  out  PC_W  request address, valid while imem_req=1
- imem_rvalid  in  1  read data valid; exactly one per request, 1..N cycles after imem_req
- imem_rdata  in  INST_W  instruction word, valid with imem_rvalid
- id_stall  in  1  decode/hazard unit holds IF/ID contents
- redirect_en  in  1  branch/jump taken; one-cycle pulse
- redirect_pc  in  PC_W  target address, valid with redirect_en
- id_valid  out  1  IF/ID holds a live instruction
- id_inst  out  INST_W  IF/ID instruction (NOP 16'h0000 when invalid)
- id_pc_plus1  out  PC_W  IF/ID address of next sequential instruction

## Operation
- FSM states: IDLE, FETCH, WAIT, BLOCKED, DISCARD. Reset state IDLE.
- IDLE: one cycle after reset release, -> FETCH.
- FETCH: imem_req=1, imem_addr=pc; -> WAIT.
- WAIT: on imem_rvalid: if IF/ID free (id_valid=0 or id_stall=0) load IF/ID {inst, pc+1, valid=1}, pc<=pc+1, -> FETCH; else write holding buffer, pc<=pc+1, -> BLOCKED.
- BLOCKED: when id_stall=0, IF/ID <= buffer, buffer cleared, -> FETCH.
- DISCARD: await imem_rvalid, drop data, -> FETCH.
- IF/ID update when id_stall=0 and no new data this cycle: id_valid<=0, id_inst<=NOP.
- Redirect (any state, priority over stall and rvalid): pc<=redirect_pc, id_valid<=0, id_inst<=NOP, buffer cleared; state -> DISCARD if in WAIT with imem_rvalid=0, else -> FETCH (a same-cycle rvalid is consumed and dropped).
- Redirect during FETCH: request issued that cycle is outstanding -> DISCARD.
- PC arithmetic modulo 2^PC_W; pc=16'hFFFF wraps to 0, id_pc_plus1=0.
- Never more than one outstanding request; imem_req never asserted in WAIT, BLOCKED, DISCARD.

## Timing
- Reset values: imem_req=0, imem_addr=RESET_PC, id_valid=0, id_inst=16'h0000, id_pc_plus1=0, pc=RESET_PC.
- imem_req/imem_addr combinational from state and pc; IF/ID outputs registered.
- 1-cycle memory: req in cycle n, rvalid in n+1, IF/ID visible in n+2; steady throughput one instruction per 2 cycles.
- First request: second rising edge after reset deassertion.
- Redirect in cycle n: first request to redirect_pc in n+1 (FETCH) or cycle after the dropped response (DISCARD).
- Reset mid-operation: all state cleared immediately; a later stray imem_rvalid in IDLE is ignored.

## Structure
- Shared package mips_pkg: INST_W, PC_W, NOP_INST (16'h0000), if_state_t enum.
- One sub-module: if_hold_buf (single-entry inst/pc_plus1 register with valid, load/clear/pop); FSM and PC in if_stage.

## Test plan
- Reset, 1-cycle memory returning mem[a]=16'h1000+a -> requests to 0,1,2 every 2 cycles; id_inst 16'h1000 valid with id_pc_plus1=1 in cycle 3 after reset release.
- 3-cycle memory latency -> imem_req only every 4 cycles, no second request while outstanding, IF/ID order preserved.
- id_stall held 5 cycles while inst @2 returns -> id_inst stays @1, buffer takes @2, no request issued; stall drop -> @2 appears next cycle, then fetch of 3.
- redirect_en with redirect_pc=16'h0040 while WAIT, response arrives 2 cycles later -> response dropped, id_valid=0, next request addr 16'h0040.
- redirect_en same cycle as imem_rvalid and id_stall=1 -> data dropped, buffer cleared, request to target next cycle.
- RESET_PC=16'hFFFF -> fetch 16'hFFFF with id_pc_plus1=0, next request addr 0; rst asserted mid-WAIT -> outputs at reset values same cycle.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared types and constants for the 16-bit MIPS pipeline.
package mips_pkg;
  localparam int unsigned INST_W = 16;
  localparam int unsigned PC_W   = 16;

  localparam logic [INST_W-1:0] NOP_INST = 16'h0000;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT,
    BLOCKED,
    DISCARD
  } if_state_t;
endpackage

// File: rtl/if_hold_buf.sv
// Single-entry holding buffer for a fetched instruction that decode could not accept.
module if_hold_buf #(
  parameter int unsigned INST_W = mips_pkg::INST_W,
  parameter int unsigned PC_W   = mips_pkg::PC_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              pop,
  input  logic              clear,
  input  logic [INST_W-1:0] in_inst,
  input  logic [PC_W-1:0]   in_pc_plus1,
  output logic              valid,
  output logic [INST_W-1:0] inst,
  output logic [PC_W-1:0]   pc_plus1
);
  import mips_pkg::*;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid    <= 1'b0;
      inst     <= INST_W'(NOP_INST);
      pc_plus1 <= '0;
    end else if (clear || pop) begin
      valid    <= 1'b0;
    end else if (load) begin
      valid    <= 1'b1;
      inst     <= in_inst;
      pc_plus1 <= in_pc_plus1;
    end
  end
endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC, single-outstanding imem requests, IF/ID register,
// stall holding buffer and redirect flush.
module if_stage #(
  parameter int unsigned      PC_W     = mips_pkg::PC_W,
  parameter int unsigned      INST_W   = mips_pkg::INST_W,
  parameter logic [PC_W-1:0]  RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [PC_W-1:0]   imem_addr,
  input  logic              imem_rvalid,
  input  logic [INST_W-1:0] imem_rdata,
  input  logic              id_stall,
  input  logic              redirect_en,
  input  logic [PC_W-1:0]   redirect_pc,
  output logic              id_valid,
  output logic [INST_W-1:0] id_inst,
  output logic [PC_W-1:0]   id_pc_plus1
);
  import mips_pkg::*;

  if_state_t         state, state_next;
  logic [PC_W-1:0]   pc, pc_plus1;
  logic              ifid_free, take_resp, buf_load, buf_pop;
  logic              buf_valid;
  logic [INST_W-1:0] buf_inst;
  logic [PC_W-1:0]   buf_pc_plus1;

  always_comb begin
    pc_plus1  = pc + PC_W'(1);
    ifid_free = !id_valid || !id_stall;
    take_resp = (state == WAIT) && imem_rvalid && !redirect_en;
    buf_load  = take_resp && !ifid_free;
    buf_pop   = (state == BLOCKED) && buf_valid && !id_stall && !redirect_en;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    state_next = FETCH;
      FETCH:   state_next = redirect_en ? DISCARD : WAIT;
      WAIT: begin
        if (redirect_en)      state_next = imem_rvalid ? FETCH : DISCARD;
        else if (imem_rvalid) state_next = ifid_free ? FETCH : BLOCKED;
      end
      BLOCKED: if (redirect_en || !id_stall) state_next = FETCH;
      // A redirect here keeps waiting: the old request is still outstanding.
      DISCARD: if (imem_rvalid) state_next = FETCH;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    imem_req  = (state == FETCH);
    imem_addr = pc;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)              pc <= RESET_PC;
    else if (redirect_en) pc <= redirect_pc;
    else if (take_resp)   pc <= pc_plus1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id_valid    <= 1'b0;
      id_inst     <= INST_W'(NOP_INST);
      id_pc_plus1 <= '0;
    end else if (redirect_en) begin
      id_valid    <= 1'b0;
      id_inst     <= INST_W'(NOP_INST);
    end else if (take_resp && ifid_free) begin
      id_valid    <= 1'b1;
      id_inst     <= imem_rdata;
      id_pc_plus1 <= pc_plus1;
    end else if (buf_pop) begin
      id_valid    <= 1'b1;
      id_inst     <= buf_inst;
      id_pc_plus1 <= buf_pc_plus1;
    end else if (!id_stall) begin
      id_valid    <= 1'b0;
      id_inst     <= INST_W'(NOP_INST);
    end
  end

  if_hold_buf #(
    .INST_W (INST_W),
    .PC_W   (PC_W)
  ) u_hold_buf (
    .clk         (clk),
    .rst         (rst),
    .load        (buf_load),
    .pop         (buf_pop),
    .clear       (redirect_en),
    .in_inst     (imem_rdata),
    .in_pc_plus1 (pc_plus1),
    .valid       (buf_valid),
    .inst        (buf_inst),
    .pc_plus1    (buf_pc_plus1)
  );
endmodule
